// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: execute stage with valid/ready handshake, multi-cycle multiply.
// Define OVERFLOW_DET_EN to add the registered signed-overflow flag ovf.
module ex_stage_pipe #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int MUL_LAT = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         op,
    input  logic [DATA_W-1:0]  rs,
    input  logic [DATA_W-1:0]  rt,
    input  logic [DATA_W-1:0]  imm,
    input  logic [DATA_W-1:0]  pc4,
    input  logic [RADDR_W-1:0] rd_addr_in,
    input  logic               mem_read_in,
    input  logic               mem_write_in,
    input  logic               mem_to_reg_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic [DATA_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  store_data,
    output logic               br_taken,
    output logic [DATA_W-1:0]  br_target,
    output logic               halt,
    output logic [RADDR_W-1:0] rd_addr_out,
    output logic               mem_read_out,
    output logic               mem_write_out,
`ifdef OVERFLOW_DET_EN
    output logic               ovf,
`endif
    output logic               mem_to_reg_out
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam int MSB   = DATA_W - 1;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_SUBI = 6'h03;
    localparam logic [5:0] OP_MUL  = 6'h04;
    localparam logic [5:0] OP_MULI = 6'h05;
    localparam logic [5:0] OP_OR   = 6'h06;
    localparam logic [5:0] OP_ORI  = 6'h07;
    localparam logic [5:0] OP_AND  = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h09;
    localparam logic [5:0] OP_XOR  = 6'h0A;
    localparam logic [5:0] OP_XORI = 6'h0B;
    localparam logic [5:0] OP_LDW  = 6'h0C;
    localparam logic [5:0] OP_STW  = 6'h0D;
    localparam logic [5:0] OP_BZ   = 6'h0E;
    localparam logic [5:0] OP_BEQ  = 6'h0F;
    localparam logic [5:0] OP_JR   = 6'h10;
    localparam logic [5:0] OP_HALT = 6'h11;

    typedef enum logic [0:0] {
        S_IDLE,
        S_MUL_BUSY
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0]  result;
        logic [DATA_W-1:0]  mem_addr;
        logic [DATA_W-1:0]  store_data;
        logic               br_taken;
        logic [DATA_W-1:0]  br_target;
        logic               halt;
        logic [RADDR_W-1:0] rd_addr;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
`ifdef OVERFLOW_DET_EN
        logic               ovf;
`endif
    } ex_out_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  mul_a_q, mul_b_q;
    logic [RADDR_W-1:0] mul_rd_q;
    logic               mul_mr_q, mul_mw_q, mul_mtr_q;
    ex_out_t            out_q, exec_pkt, mul_pkt;
    logic               out_valid_q;

    logic               accept, is_mul, use_imm;
    logic               load_exec, load_mul, latch_mul;
    logic [DATA_W-1:0]  opb, sum, diff, prod;
    logic [DATA_W-1:0]  mul_a, mul_b, br_dest;
`ifdef OVERFLOW_DET_EN
    logic               add_ovf, sub_ovf;
`endif

    assign use_imm = op[0] && (op <= OP_XORI);
    assign opb     = use_imm ? imm : rt;
    assign sum     = rs + opb;
    assign diff    = rs + ~opb + 1'b1;
    assign br_dest = pc4 + (imm << 2);
    assign is_mul  = (op == OP_MUL) || (op == OP_MULI);

`ifdef OVERFLOW_DET_EN
    assign add_ovf = (rs[MSB] == opb[MSB]) && (sum[MSB] != rs[MSB]);
    assign sub_ovf = (rs[MSB] != opb[MSB]) && (diff[MSB] != rs[MSB]);
`endif

    // One multiplier, fed from live operands or the latched pair while busy.
    // Low half of the product is identical for signed and unsigned operands.
    assign mul_a = (state_q == S_MUL_BUSY) ? mul_a_q : rs;
    assign mul_b = (state_q == S_MUL_BUSY) ? mul_b_q : opb;
    assign prod  = mul_a * mul_b;

    always_comb begin
        exec_pkt            = '0;
        exec_pkt.rd_addr    = rd_addr_in;
        exec_pkt.mem_read   = mem_read_in;
        exec_pkt.mem_write  = mem_write_in;
        exec_pkt.mem_to_reg = mem_to_reg_in;
        unique case (op)
            OP_ADD, OP_ADDI: begin
                exec_pkt.result = sum;
`ifdef OVERFLOW_DET_EN
                exec_pkt.ovf = add_ovf;
`endif
            end
            OP_SUB, OP_SUBI: begin
                exec_pkt.result = diff;
`ifdef OVERFLOW_DET_EN
                exec_pkt.ovf = sub_ovf;
`endif
            end
            OP_MUL, OP_MULI: exec_pkt.result = prod;
            OP_OR, OP_ORI:   exec_pkt.result = rs | opb;
            OP_AND, OP_ANDI: exec_pkt.result = rs & opb;
            OP_XOR, OP_XORI: exec_pkt.result = rs ^ opb;
            OP_LDW: exec_pkt.mem_addr = rs + imm;
            OP_STW: begin
                exec_pkt.mem_addr   = rs + imm;
                exec_pkt.store_data = rt;
            end
            OP_BZ: begin
                exec_pkt.br_taken  = (rs == '0);
                exec_pkt.br_target = (rs == '0) ? br_dest : pc4;
            end
            OP_BEQ: begin
                exec_pkt.br_taken  = (rs == rt);
                exec_pkt.br_target = (rs == rt) ? br_dest : pc4;
            end
            OP_JR: begin
                exec_pkt.br_taken  = 1'b1;
                exec_pkt.br_target = rs;
            end
            OP_HALT: exec_pkt.halt = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        mul_pkt            = '0;
        mul_pkt.result     = prod;
        mul_pkt.rd_addr    = mul_rd_q;
        mul_pkt.mem_read   = mul_mr_q;
        mul_pkt.mem_write  = mul_mw_q;
        mul_pkt.mem_to_reg = mul_mtr_q;
    end

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_exec = 1'b0;
        load_mul  = 1'b0;
        latch_mul = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul && (MUL_LAT > 1)) begin
                        state_d   = S_MUL_BUSY;
                        cnt_d     = CNT_W'(MUL_LAT - 1);
                        latch_mul = 1'b1;
                    end else begin
                        load_exec = 1'b1;
                    end
                end
            end
            S_MUL_BUSY: begin
                // Product lands on the edge where the count reaches zero.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    load_mul = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_rd_q  <= '0;
            mul_mr_q  <= 1'b0;
            mul_mw_q  <= 1'b0;
            mul_mtr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_mul) begin
                mul_a_q   <= rs;
                mul_b_q   <= opb;
                mul_rd_q  <= rd_addr_in;
                mul_mr_q  <= mem_read_in;
                mul_mw_q  <= mem_write_in;
                mul_mtr_q <= mem_to_reg_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (load_exec) begin
            out_q       <= exec_pkt;
            out_valid_q <= 1'b1;
        end else if (load_mul) begin
            out_q       <= mul_pkt;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid      = out_valid_q;
    assign result         = out_q.result;
    assign mem_addr       = out_q.mem_addr;
    assign store_data     = out_q.store_data;
    assign br_taken       = out_valid_q && out_q.br_taken;
    assign br_target      = out_q.br_target;
    assign halt           = out_valid_q && out_q.halt;
    assign rd_addr_out    = out_q.rd_addr;
    assign mem_read_out   = out_q.mem_read;
    assign mem_write_out  = out_q.mem_write;
    assign mem_to_reg_out = out_q.mem_to_reg;
`ifdef OVERFLOW_DET_EN
    assign ovf            = out_q.ovf;
`endif

endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: directed and random checks of ex_stage_pipe.
// Compiles with or without OVERFLOW_DET_EN.
module tb_ex_stage_pipe;

    localparam int MUL_LAT = 3;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        mr;
        logic        mw;
        logic        mtr;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [5:0]  op;
    logic [31:0] rs, rt, imm, pc4;
    logic [4:0]  rd_addr_in;
    logic        mem_read_in, mem_write_in, mem_to_reg_in;
    logic        out_valid, out_ready;
    logic [31:0] result, mem_addr, store_data, br_target;
    logic        br_taken, halt;
    logic [4:0]  rd_addr_out;
    logic        mem_read_out, mem_write_out, mem_to_reg_out;
`ifdef OVERFLOW_DET_EN
    logic        ovf;
`endif

    int checks   = 0;
    int failures = 0;

    ex_stage_pipe #(
        .DATA_W(32),
        .RADDR_W(5),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op(op),
        .rs(rs),
        .rt(rt),
        .imm(imm),
        .pc4(pc4),
        .rd_addr_in(rd_addr_in),
        .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in),
        .mem_to_reg_in(mem_to_reg_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .mem_addr(mem_addr),
        .store_data(store_data),
        .br_taken(br_taken),
        .br_target(br_target),
        .halt(halt),
        .rd_addr_out(rd_addr_out),
        .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out),
`ifdef OVERFLOW_DET_EN
        .ovf(ovf),
`endif
        .mem_to_reg_out(mem_to_reg_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] obs,
                         input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [139:0] dut_vec();
        logic o;
        o = 1'b0;
`ifdef OVERFLOW_DET_EN
        o = ovf;
`endif
        return {result, mem_addr, store_data, br_taken, br_target, halt,
                rd_addr_out, mem_read_out, mem_write_out, mem_to_reg_out, o};
    endfunction

    // Reference: what the instruction means, using wide signed arithmetic.
    function automatic logic [139:0] model_vec(input txn_t t);
        logic [31:0] res, addr, sdata, tgt, opnd;
        logic        tk, hlt, ov;
        longint      sa, sb, full;
        res = '0; addr = '0; sdata = '0; tgt = '0;
        tk = 1'b0; hlt = 1'b0; ov = 1'b0; full = 0;
        opnd = (t.op inside {6'd1, 6'd3, 6'd5, 6'd7, 6'd9, 6'd11}) ? t.imm : t.b;
        sa = $signed(t.a);
        sb = $signed(opnd);
        case (t.op)
            6'd0, 6'd1: full = sa + sb;
            6'd2, 6'd3: full = sa - sb;
            6'd4, 6'd5: full = sa * sb;
            default: ;
        endcase
        case (t.op)
            6'd0, 6'd1, 6'd2, 6'd3: begin
                res = full[31:0];
                ov  = (full > 2147483647) || (full < -longint'(2147483647) - 1);
            end
            6'd4, 6'd5: res = full[31:0];
            6'd6, 6'd7: res = t.a | opnd;
            6'd8, 6'd9: res = t.a & opnd;
            6'd10, 6'd11: res = t.a ^ opnd;
            6'd12: addr = t.a + t.imm;
            6'd13: begin
                addr  = t.a + t.imm;
                sdata = t.b;
            end
            6'd14, 6'd15: begin
                tk  = (t.op == 6'd14) ? (t.a == 0) : (t.a == t.b);
                tgt = tk ? t.pc4 + t.imm * 4 : t.pc4;
            end
            6'd16: begin
                tk  = 1'b1;
                tgt = t.a;
            end
            6'd17: hlt = 1'b1;
            default: ;
        endcase
`ifndef OVERFLOW_DET_EN
        ov = 1'b0;
`endif
        return {res, addr, sdata, tk, tgt, hlt, t.rd, t.mr, t.mw, t.mtr, ov};
    endfunction

    function automatic txn_t mk(input logic [5:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] i,
                                input logic [31:0] p);
        txn_t t;
        t.op = o; t.a = a; t.b = b; t.imm = i; t.pc4 = p;
        t.rd = 5'($urandom);
        t.mr = 1'($urandom); t.mw = 1'($urandom); t.mtr = 1'($urandom);
        return t;
    endfunction

    function automatic txn_t rand_txn(input bit allow_mul);
        txn_t t;
        logic [5:0] o;
        o = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(18, 63))
                                        : 6'($urandom_range(0, 17));
        if (!allow_mul && (o == 6'd4 || o == 6'd5)) o = 6'd6;
        t = mk(o, $urandom, $urandom, $urandom, $urandom & 32'hFFFF_FFFC);
        if ($urandom_range(0, 3) == 0) t.b = t.a;
        if ($urandom_range(0, 5) == 0) t.a = '0;
        return t;
    endfunction

    task automatic drive(input txn_t t);
        op = t.op; rs = t.a; rt = t.b; imm = t.imm; pc4 = t.pc4;
        rd_addr_in = t.rd; mem_read_in = t.mr;
        mem_write_in = t.mw; mem_to_reg_in = t.mtr;
    endtask

    // Single transaction with out_ready held high; checks exact latency.
    task automatic run_one(input string tag, input txn_t t);
        int lat;
        lat = (t.op == 6'd4 || t.op == 6'd5) ? MUL_LAT : 1;
        @(negedge clk);
        check({tag, "_ready"}, 160'(in_ready), 160'(1'b1));
        drive(t);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) begin
                check({tag, "_stall"}, 160'({out_valid, in_ready}), 160'(2'b00));
            end else begin
                check({tag, "_valid"}, 160'(out_valid), 160'(1'b1));
                check(tag, 160'(dut_vec()), 160'(model_vec(t)));
            end
        end
    endtask

    initial begin
        txn_t t, ldw, nxt;
        txn_t sq[$];

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(mk(6'd0, 32'd0, 32'd0, 32'd0, 32'd0));
        #1;
        check("reset_out", 160'({out_valid, dut_vec()}), 160'(0));
        check("reset_ready", 160'(in_ready), 160'(1'b1));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_one("add_ovf", mk(6'h00, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0));
        run_one("subi", mk(6'h03, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'd0));
        run_one("sub_min", mk(6'h02, 32'd0, 32'h8000_0000, 32'd0, 32'd0));
        run_one("mul", mk(6'h04, 32'hFFFF_FFFE, 32'd7, 32'd0, 32'd0));
        run_one("muli", mk(6'h05, 32'd12345, 32'd0, 32'hFFFF_FF00, 32'd0));
        run_one("beq_t", mk(6'h0F, 32'd9, 32'd9, 32'd4, 32'h100));
        run_one("beq_nt", mk(6'h0F, 32'd9, 32'd8, 32'd4, 32'h100));
        run_one("bz_t", mk(6'h0E, 32'd0, 32'd3, 32'hFFFF_FFFE, 32'h40));
        run_one("jr", mk(6'h10, 32'hDEAD_BEE0, 32'd0, 32'd0, 32'h44));
        run_one("halt", mk(6'h11, 32'd1, 32'd2, 32'd3, 32'h48));
        run_one("stw", mk(6'h0D, 32'h2000, 32'hCAFE_F00D, 32'h10, 32'd0));
        run_one("nop", mk(6'h3F, 32'h55, 32'h66, 32'h77, 32'h88));

        // Back-pressure: LDW held for three cycles while an ADD waits.
        ldw = mk(6'h0C, 32'h1000, 32'h1234, 32'h20, 32'd0);
        nxt = mk(6'h00, 32'd3, 32'd4, 32'd0, 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        drive(ldw);
        in_valid = 1'b1;
        @(posedge clk);
        #1 drive(nxt);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold", 160'({out_valid, in_ready, dut_vec()}),
                  160'({2'b10, model_vec(ldw)}));
            check("hold_br", 160'({br_taken, halt}), 160'(2'b00));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("after_hold", 160'({out_valid, dut_vec()}),
              160'({1'b1, model_vec(nxt)}));
        in_valid = 1'b0;
        @(negedge clk);
        check("drained", 160'({out_valid, br_taken, halt}), 160'(3'b000));

        // Back-to-back stream of single-cycle ops.
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) begin
                check("stream", 160'({out_valid, in_ready, dut_vec()}),
                      160'({2'b11, model_vec(sq.pop_front())}));
            end
            if (i < 20) begin
                t = rand_txn(1'b0);
                sq.push_back(t);
                drive(t);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end

        for (int i = 0; i < 40; i++) begin
            run_one("rand", rand_txn(1'b1));
        end

        // Reset while a multiply is in flight.
        run_one("pre_rst", mk(6'h00, 32'd1, 32'd1, 32'd0, 32'd0));
        @(negedge clk);
        drive(mk(6'h04, 32'd6, 32'd7, 32'd0, 32'd0));
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("busy_before_rst", 160'(in_ready), 160'(1'b0));
        reset = 1'b1;
        #1;
        check("rst_mid_out", 160'({out_valid, dut_vec()}), 160'(0));
        check("rst_mid_ready", 160'(in_ready), 160'(1'b1));
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < MUL_LAT + 2; k++) begin
            @(negedge clk);
            check("no_ghost", 160'({out_valid, in_ready}), 160'(2'b01));
        end
        run_one("post_rst", mk(6'h0A, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
- Parametrised execute stage for the 5-stage core: ALU, address generation, branch/jump resolution, and ID->MEM control forwarding.
- Successor to the single-cycle fixed-width EX unit. Adds:
  - a valid/ready handshake on both sides;
  - a multi-cycle multiplier with stall;
  - an explicit branch-taken flag and separate branch target;
  - a registered output that holds under back-pressure.
- Sits between the ID/EX register and the MEM stage.

Parameters:
- DATA_W, 32, operand/result width (>=8).
- RADDR_W, 5, destination register address width.
- MUL_LAT, 3, multiply latency in cycles (>=1; 1 = single-cycle).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  ID stage presents an instruction
- in_ready  out  1  EX can accept this cycle
- op  in  6  opcode
- rs  in  DATA_W  source operand A
- rt  in  DATA_W  source operand B
- imm  in  DATA_W  sign-extended immediate
- pc4  in  DATA_W  PC+4 of the instruction
- rd_addr_in  in  RADDR_W  destination register
- mem_read_in, mem_write_in, mem_to_reg_in  in  1 each  control to forward
- out_valid  out  1  result registered and valid
- out_ready  in  1  MEM stage accepts
- result  out  DATA_W  ALU result (0 for non-ALU ops)
- mem_addr  out  DATA_W  LDW/STW effective address (0 otherwise)
- store_data  out  DATA_W  rt for STW (0 otherwise)
- br_taken  out  1  redirect PC
- br_target  out  DATA_W  redirect address
- halt  out  1  HALT retired
- rd_addr_out, mem_read_out, mem_write_out, mem_to_reg_out  out  forwarded control

Behaviour:
- Reset (async, immediate):
  - all outputs 0 except in_ready=1;
  - FSM to IDLE; multiply counter 0.
- Opcodes:
  - 0x00 ADD, 0x01 ADDI;
  - 0x02 SUB, 0x03 SUBI;
  - 0x04 MUL, 0x05 MULI;
  - 0x06 OR, 0x07 ORI;
  - 0x08 AND, 0x09 ANDI;
  - 0x0A XOR, 0x0B XORI;
  - 0x0C LDW, 0x0D STW;
  - 0x0E BZ, 0x0F BEQ;
  - 0x10 JR, 0x11 HALT;
  - all others NOP (result 0, control forwarded, no side effects).
- Arithmetic:
  - two's complement, modulo 2^DATA_W.
  - SUB = rs + ~rt + 1.
  - MUL keeps the low DATA_W bits of the signed product.
  - I-forms use imm in place of rt.
- LDW/STW: mem_addr = rs + imm; STW also drives store_data = rt.
- BZ: taken when rs == 0.
- BEQ: taken when rs == rt.
- Branch target: pc4 + (imm << 2), truncated to DATA_W.
- Not-taken branches: br_taken=0, br_target=pc4.
- JR: br_taken=1, br_target=rs.
- HALT: halt=1 for the one output beat.
- FSM states:
  - IDLE: accepts when in_valid && in_ready.
    - Non-MUL ops: output register loads at the accepting edge (latency 1), out_valid=1.
    - MUL/MULI with MUL_LAT>1: latch operands, go to MUL_BUSY with counter = MUL_LAT-1, in_ready=0.
  - MUL_BUSY: counter decrements each cycle. At 0 the product loads the output register, out_valid=1, return to IDLE. Total latency MUL_LAT cycles from accept.
  - Output hold: while out_valid && !out_ready, every output stays stable and in_ready=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept-and-drain in the same cycle is allowed and gives back-to-back throughput of 1/cycle.
- out_valid clears on out_ready when no new result loads that edge.
- br_taken and halt are qualified by out_valid (0 when out_valid=0).
- Reset during MUL_BUSY aborts the multiply. No output is produced.

Optional Feature:
- OVERFLOW_DET_EN defined:
  - adds output ovf (1 bit).
  - Set on ADD/ADDI/SUB/SUBI signed overflow: operand signs equal (after negation for SUB) and result sign differs.
  - 0 for all other ops; reset 0; registered with result.
- Undefined: no ovf port; wrap silently.

Test Plan:
- ADD rs=0x7FFFFFFF, rt=1, out_ready=1 -> next cycle result=0x80000000, out_valid=1; ovf=1 if OVERFLOW_DET_EN.
- SUBI rs=5, imm=0xFFFFFFFD (-3) -> result=8.
- MUL rs=0xFFFFFFFE (-2), rt=7, MUL_LAT=3:
  - in_ready=0 for 2 cycles;
  - result=0xFFFFFFF2 with out_valid 3 cycles after accept.
- BEQ rs=rt=9, pc4=0x100, imm=4 -> br_taken=1, br_target=0x110. Repeat with rt=8 -> br_taken=0, br_target=0x100.
- LDW rs=0x1000, imm=0x20, out_ready=0 for 3 cycles:
  - mem_addr=0x1020 held stable;
  - in_ready=0 throughout;
  - accepted next instruction only after out_ready=1.
- Assert reset mid MUL_BUSY -> all outputs 0 immediately, in_ready=1; no result emitted after release.
